// File: rtl/game_pkg.sv
// Shared definitions for the two-player game sequencer: FSM states,
// player codes and score counter width.
package game_pkg;

    localparam int unsigned SCORE_W = 4;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10
    } player_e;

    typedef enum logic [2:0] {
        CLEAR,
        P1_WAIT,
        P1_COMMIT,
        P2_WAIT,
        P2_COMMIT,
        CHECK,
        GAME_END,
        MATCH_END
    } state_e;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on the rising edge of a button already synchronous to clk.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= btn_i;
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Turn sequencer for a two-player board game: turn ownership, move commit,
// per-turn timeout, scoring and match termination.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TURN_TIMEOUT = 50000,
    parameter int unsigned MATCH_WINS   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               player1,
    input  logic               player2,
    input  logic               illegal_move,
    input  logic               winner,
    input  logic [1:0]         winner_player,
    input  logic               sin_espacio,
    output logic               player1_turn,
    output logic               player2_turn,
    output logic               board_clear,
    output logic [1:0]         turn_owner,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] draws,
    output logic               match_over,
    output logic               timeout_pulse,
    output logic               illegal_pulse
);

    localparam int unsigned TW = $clog2(TURN_TIMEOUT);

    state_e               state_q,   state_d;
    logic                 starter_q, starter_d;   // 0: P1 opens the next game
    logic                 mover_q,   mover_d;     // 0: P1 made the last commit
    logic [TW-1:0]        timer_q,   timer_d;
    logic [SCORE_W-1:0]   score1_q,  score1_d;
    logic [SCORE_W-1:0]   score2_q,  score2_d;
    logic [SCORE_W-1:0]   draws_q,   draws_d;
    logic                 timeout_q, timeout_d;
    logic                 illegal_q, illegal_d;
    logic                 p1_rise,   p2_rise;
    logic                 own_rise;

    rise_detect u_rise_p1 (.clk(clk), .reset(reset), .btn_i(player1), .rise_o(p1_rise));
    rise_detect u_rise_p2 (.clk(clk), .reset(reset), .btn_i(player2), .rise_o(p2_rise));

    always_comb begin
        state_d   = state_q;
        starter_d = starter_q;
        mover_d   = mover_q;
        timer_d   = '0;
        score1_d  = score1_q;
        score2_d  = score2_q;
        draws_d   = draws_q;
        timeout_d = 1'b0;
        illegal_d = 1'b0;
        own_rise  = 1'b0;

        unique case (state_q)
            CLEAR: state_d = starter_q ? P2_WAIT : P1_WAIT;

            P1_WAIT, P2_WAIT: begin
                own_rise = (state_q == P1_WAIT) ? p1_rise : p2_rise;
                // A legal press wins over an expiring timer in the same cycle.
                if (own_rise && !illegal_move) begin
                    state_d = (state_q == P1_WAIT) ? P1_COMMIT : P2_COMMIT;
                end else begin
                    illegal_d = own_rise;
                    if (timer_q == TW'(TURN_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = (state_q == P1_WAIT) ? P2_WAIT : P1_WAIT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            P1_COMMIT: begin
                mover_d = 1'b0;
                state_d = CHECK;
            end

            P2_COMMIT: begin
                mover_d = 1'b1;
                state_d = CHECK;
            end

            CHECK: begin
                if (winner) begin
                    state_d = GAME_END;
                    if (winner_player == P1) begin
                        score1_d = sat_inc(score1_q);
                        if (score1_d == SCORE_W'(MATCH_WINS)) state_d = MATCH_END;
                    end else if (winner_player == P2) begin
                        score2_d = sat_inc(score2_q);
                        if (score2_d == SCORE_W'(MATCH_WINS)) state_d = MATCH_END;
                    end
                end else if (sin_espacio) begin
                    draws_d = sat_inc(draws_q);
                    state_d = GAME_END;
                end else begin
                    state_d = mover_q ? P1_WAIT : P2_WAIT;
                end
            end

            GAME_END: begin
                if (p1_rise || p2_rise) begin
                    state_d   = CLEAR;
                    starter_d = ~starter_q;
                end
            end

            MATCH_END: state_d = MATCH_END;

            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            starter_q <= 1'b0;
            mover_q   <= 1'b0;
            timer_q   <= '0;
            score1_q  <= '0;
            score2_q  <= '0;
            draws_q   <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starter_q <= starter_d;
            mover_q   <= mover_d;
            timer_q   <= timer_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            draws_q   <= draws_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        unique case (state_q)
            P1_WAIT, P1_COMMIT: turn_owner = P1;
            P2_WAIT, P2_COMMIT: turn_owner = P2;
            default:            turn_owner = NONE;
        endcase
    end

    assign board_clear   = (state_q == CLEAR);
    assign player1_turn  = (state_q == P1_COMMIT);
    assign player2_turn  = (state_q == P2_COMMIT);
    assign match_over    = (state_q == MATCH_END);
    assign score1        = score1_q;
    assign score2        = score2_q;
    assign draws         = draws_q;
    assign timeout_pulse = timeout_q;
    assign illegal_pulse = illegal_q;

endmodule
